// File: rtl/cpu_inta_sequencer_if.sv
// Interrupt-acknowledge bus between a host-side sequencer (master) and the 8259 PIC (slave).
interface cpu_inta_sequencer_if;
    logic        INT;
    logic        IF_flag;
    logic [7:0]  D_IN;
    logic        INTA_n;
    logic        busy;
    logic [7:0]  vector;
    logic [15:0] call_addr;
    logic [7:0]  call_opcode;
    logic        vector_valid;

    modport master (
        input  INT, IF_flag, D_IN,
        output INTA_n, busy, vector, call_addr, call_opcode, vector_valid
    );

    modport slave (
        output INT, IF_flag, D_IN,
        input  INTA_n, busy, vector, call_addr, call_opcode, vector_valid
    );
endinterface

// File: rtl/cpu_inta_sequencer.sv
// Host-side 8259 interrupt-acknowledge sequencer: issues the INTA_n pulse train
// (2 pulses for 8086, 3 for 8080) and captures the bytes the PIC returns.
module cpu_inta_sequencer #(
    parameter bit MODE_8086    = 1'b1,
    parameter int INTA_LOW_CYC = 2,
    parameter int INTA_GAP_CYC = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_inta_sequencer_if.master bus
);

    localparam int CNT_MAX = (INTA_LOW_CYC > INTA_GAP_CYC) ? INTA_LOW_CYC : INTA_GAP_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] LOW_END    = CNT_W'(INTA_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_END    = CNT_W'(INTA_GAP_CYC - 1);
    localparam logic [1:0]       LAST_PULSE = MODE_8086 ? 2'd2 : 2'd3;

    typedef enum logic [2:0] {IDLE, ARM, LOW, GAP, DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       pidx;
    logic             low_last, gap_last;
    logic [7:0]       vector_q;
    logic [15:0]      call_addr_q;
    logic [7:0]       call_opcode_q;

    assign low_last = (cnt == LOW_END);
    assign gap_last = (cnt == GAP_END);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.INT && bus.IF_flag) state_next = ARM;
            // Second look at INT rejects single-cycle glitches before any pulse goes out.
            ARM:  state_next = bus.INT ? LOW : IDLE;
            LOW:  if (low_last) state_next = (pidx == LAST_PULSE) ? DONE : GAP;
            GAP:  if (gap_last) state_next = LOW;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.INTA_n       = (state != LOW);
        bus.busy         = (state == LOW) || (state == GAP);
        bus.vector_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            pidx <= 2'd0;
        end else begin
            case (state)
                ARM: begin
                    cnt  <= '0;
                    pidx <= 2'd1;
                end
                LOW: cnt <= low_last ? '0 : cnt + CNT_W'(1);
                GAP: begin
                    cnt <= gap_last ? '0 : cnt + CNT_W'(1);
                    if (gap_last) pidx <= pidx + 2'd1;
                end
                default: cnt <= '0;
            endcase
        end
    end

    // D_IN is only trusted on the final low cycle of each pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            vector_q      <= 8'h00;
            call_addr_q   <= 16'h0000;
            call_opcode_q <= 8'h00;
        end else if (state == LOW && low_last) begin
            if (MODE_8086) begin
                if (pidx == 2'd2) vector_q <= bus.D_IN;
            end else begin
                case (pidx)
                    2'd1: call_opcode_q <= bus.D_IN;
                    2'd2: begin
                        vector_q         <= bus.D_IN;
                        call_addr_q[7:0] <= bus.D_IN;
                    end
                    2'd3: call_addr_q[15:8] <= bus.D_IN;
                    default: ;
                endcase
            end
        end
    end

    assign bus.vector      = vector_q;
    assign bus.call_addr   = call_addr_q;
    assign bus.call_opcode = call_opcode_q;

endmodule

// File: tb/tb_cpu_inta_sequencer.sv
// Directed bench for cpu_inta_sequencer: one 8086-mode and one 8080-mode instance,
// each answered by a small PIC model that returns a per-pulse byte on D_IN.
module tb_cpu_inta_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    cpu_inta_sequencer_if b1 ();
    cpu_inta_sequencer_if b0 ();

    cpu_inta_sequencer #(.MODE_8086(1'b1), .INTA_LOW_CYC(2), .INTA_GAP_CYC(2)) dut1 (
        .clk(clk), .reset(reset), .bus(b1)
    );
    cpu_inta_sequencer #(.MODE_8086(1'b0), .INTA_LOW_CYC(2), .INTA_GAP_CYC(2)) dut0 (
        .clk(clk), .reset(reset), .bus(b0)
    );

    // PIC models: count INTA_n falling edges and present the matching byte while low.
    logic [7:0] bytes1 [3];
    logic [7:0] bytes0 [3];
    int pcnt1 = 0, pcnt0 = 0;
    logic prev1 = 1'b1, prev0 = 1'b1;

    always @(negedge clk) begin
        if (reset) pcnt1 = 0;
        else if (!b1.INTA_n && prev1) pcnt1 = pcnt1 + 1;
        prev1 = b1.INTA_n;
        b1.D_IN = (!b1.INTA_n && pcnt1 >= 1 && pcnt1 <= 3) ? bytes1[pcnt1-1] : 8'hFF;
        if (b1.vector_valid) pcnt1 = 0;
    end

    always @(negedge clk) begin
        if (reset) pcnt0 = 0;
        else if (!b0.INTA_n && prev0) pcnt0 = pcnt0 + 1;
        prev0 = b0.INTA_n;
        b0.D_IN = (!b0.INTA_n && pcnt0 >= 1 && pcnt0 <= 3) ? bytes0[pcnt0-1] : 8'hFF;
        if (b0.vector_valid) pcnt0 = 0;
    end

    task automatic test_reset();
        reset = 1'b1;
        b1.INT = 1'b1; b1.IF_flag = 1'b1;
        b0.INT = 1'b1; b0.IF_flag = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (b1.INTA_n !== 1'b1 || b1.busy !== 1'b0 || b1.vector_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_m1_ctrl: got inta_n=%b busy=%b vv=%b, expected 1 0 0", b1.INTA_n, b1.busy, b1.vector_valid);
        end
        tests_run++;
        if (b1.vector !== 8'h00 || b1.call_addr !== 16'h0000 || b1.call_opcode !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_m1_data: got %h %h %h, expected 00 0000 00", b1.vector, b1.call_addr, b1.call_opcode);
        end
        tests_run++;
        if (b0.INTA_n !== 1'b1 || b0.busy !== 1'b0 || b0.vector_valid !== 1'b0 ||
            b0.vector !== 8'h00 || b0.call_addr !== 16'h0000 || b0.call_opcode !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_m0: got inta_n=%b busy=%b vv=%b %h %h %h, expected 1 0 0 00 0000 00",
                     b0.INTA_n, b0.busy, b0.vector_valid, b0.vector, b0.call_addr, b0.call_opcode);
        end
        reset = 1'b0;
        b1.INT = 1'b0; b0.INT = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // k counts negedges after INT is raised; negedge k shows cycle k+1 of the handshake.
    // Mode 1: lows at k=2,3 and 6,7; DONE (vector_valid) at k=8.
    task automatic test_mode1();
        bytes1[0] = 8'h20; bytes1[1] = 8'h4A; bytes1[2] = 8'hEE;
        b1.IF_flag = 1'b1; b1.INT = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            tests_run++;
            if (b1.INTA_n !== !(k == 2 || k == 3 || k == 6 || k == 7)) begin
                tests_failed++;
                $display("FAIL m1_inta k=%0d: got %b, expected %b", k, b1.INTA_n, !(k == 2 || k == 3 || k == 6 || k == 7));
            end
            tests_run++;
            if (b1.busy !== (k >= 2 && k <= 7) || b1.vector_valid !== (k == 8)) begin
                tests_failed++;
                $display("FAIL m1_busy_vv k=%0d: got busy=%b vv=%b, expected %b %b", k, b1.busy, b1.vector_valid, (k >= 2 && k <= 7), (k == 8));
            end
            if (k == 4) begin
                tests_run++;
                if (b1.vector !== 8'h00) begin
                    tests_failed++;
                    $display("FAIL m1_pulse1_discard: got %h, expected 00", b1.vector);
                end
            end
            if (k == 8) b1.INT = 1'b0;
        end
        tests_run++;
        if (b1.vector !== 8'h4A || b1.call_addr !== 16'h0000 || b1.call_opcode !== 8'h00) begin
            tests_failed++;
            $display("FAIL m1_capture: got %h %h %h, expected 4a 0000 00", b1.vector, b1.call_addr, b1.call_opcode);
        end
    endtask

    // Mode 0: lows at k=2,3 / 6,7 / 10,11; DONE at k=12.
    task automatic test_mode0();
        bytes0[0] = 8'hCD; bytes0[1] = 8'h34; bytes0[2] = 8'h12;
        b0.IF_flag = 1'b1; b0.INT = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            tests_run++;
            if (b0.INTA_n !== !(k == 2 || k == 3 || k == 6 || k == 7 || k == 10 || k == 11)) begin
                tests_failed++;
                $display("FAIL m0_inta k=%0d: got %b", k, b0.INTA_n);
            end
            tests_run++;
            if (b0.busy !== (k >= 2 && k <= 11) || b0.vector_valid !== (k == 12)) begin
                tests_failed++;
                $display("FAIL m0_busy_vv k=%0d: got busy=%b vv=%b, expected %b %b", k, b0.busy, b0.vector_valid, (k >= 2 && k <= 11), (k == 12));
            end
            if (k == 4) begin
                tests_run++;
                if (b0.call_opcode !== 8'hCD || b0.vector !== 8'h00) begin
                    tests_failed++;
                    $display("FAIL m0_pulse1: got opcode=%h vector=%h, expected cd 00", b0.call_opcode, b0.vector);
                end
            end
            if (k == 8) begin
                tests_run++;
                if (b0.vector !== 8'h34 || b0.call_addr !== 16'h0034) begin
                    tests_failed++;
                    $display("FAIL m0_pulse2: got vector=%h addr=%h, expected 34 0034", b0.vector, b0.call_addr);
                end
            end
            if (k == 12) b0.INT = 1'b0;
        end
        tests_run++;
        if (b0.call_opcode !== 8'hCD || b0.call_addr !== 16'h1234 || b0.vector !== 8'h34) begin
            tests_failed++;
            $display("FAIL m0_capture: got %h %h %h, expected cd 1234 34", b0.call_opcode, b0.call_addr, b0.vector);
        end
    endtask

    task automatic test_gating();
        int lows = 0;
        int vvs  = 0;
        b1.IF_flag = 1'b0; b1.INT = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!b1.INTA_n || b1.busy) lows++;
        end
        tests_run++;
        if (lows !== 0) begin
            tests_failed++;
            $display("FAIL gate_if0: got %0d active cycles, expected 0", lows);
        end
        b1.INT = 1'b0; b1.IF_flag = 1'b1;
        @(negedge clk);
        b1.INT = 1'b1;
        @(negedge clk);
        b1.INT = 1'b0;
        lows = 0;
        repeat (6) begin
            @(negedge clk);
            if (!b1.INTA_n) lows++;
            if (b1.vector_valid) vvs++;
        end
        tests_run++;
        if (lows !== 0 || vvs !== 0) begin
            tests_failed++;
            $display("FAIL glitch_reject: got lows=%0d vv=%0d, expected 0 0", lows, vvs);
        end
        tests_run++;
        if (b1.vector !== 8'h4A) begin
            tests_failed++;
            $display("FAIL glitch_vector_hold: got %h, expected 4a", b1.vector);
        end
    endtask

    task automatic test_int_drop();
        bytes1[0] = 8'h99; bytes1[1] = 8'h6C; bytes1[2] = 8'hEE;
        b1.IF_flag = 1'b1; b1.INT = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 2) begin
                b1.INT = 1'b0; b1.IF_flag = 1'b0;
            end
            tests_run++;
            if (b1.INTA_n !== !(k == 2 || k == 3 || k == 6 || k == 7) || b1.vector_valid !== (k == 8)) begin
                tests_failed++;
                $display("FAIL drop_seq k=%0d: got inta_n=%b vv=%b, expected %b %b", k, b1.INTA_n, b1.vector_valid,
                         !(k == 2 || k == 3 || k == 6 || k == 7), (k == 8));
            end
        end
        tests_run++;
        if (b1.vector !== 8'h6C) begin
            tests_failed++;
            $display("FAIL drop_vector: got %h, expected 6c", b1.vector);
        end
    endtask

    // INT held through DONE: one idle cycle (k=9), ARM (k=10), second train k=11..16, DONE k=17.
    task automatic test_back_to_back();
        bytes1[0] = 8'h11; bytes1[1] = 8'h5B; bytes1[2] = 8'hEE;
        b1.IF_flag = 1'b1; b1.INT = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 11) b1.INT = 1'b0;
            tests_run++;
            if (b1.INTA_n !== !(k == 2 || k == 3 || k == 6 || k == 7 || k == 11 || k == 12 || k == 15 || k == 16) ||
                b1.vector_valid !== (k == 8 || k == 17)) begin
                tests_failed++;
                $display("FAIL b2b k=%0d: got inta_n=%b vv=%b", k, b1.INTA_n, b1.vector_valid);
            end
        end
        tests_run++;
        if (b1.vector !== 8'h5B) begin
            tests_failed++;
            $display("FAIL b2b_vector: got %h, expected 5b", b1.vector);
        end
    endtask

    task automatic test_reset_mid();
        int lows = 0;
        int vvs  = 0;
        bytes1[0] = 8'h01; bytes1[1] = 8'h77; bytes1[2] = 8'hEE;
        b1.IF_flag = 1'b1; b1.INT = 1'b1;
        repeat (6) @(negedge clk);
        tests_run++;
        if (b1.INTA_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_in_low: got %b, expected 0", b1.INTA_n);
        end
        reset = 1'b1; b1.INT = 1'b0;
        @(negedge clk);
        tests_run++;
        if (b1.INTA_n !== 1'b1 || b1.busy !== 1'b0 || b1.vector_valid !== 1'b0 || b1.vector !== 8'h00) begin
            tests_failed++;
            $display("FAIL rstmid_abort: got inta_n=%b busy=%b vv=%b vector=%h, expected 1 0 0 00",
                     b1.INTA_n, b1.busy, b1.vector_valid, b1.vector);
        end
        tests_run++;
        if (b0.call_addr !== 16'h0000 || b0.call_opcode !== 8'h00) begin
            tests_failed++;
            $display("FAIL rstmid_m0_clear: got %h %h, expected 0000 00", b0.call_addr, b0.call_opcode);
        end
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (!b1.INTA_n) lows++;
            if (b1.vector_valid) vvs++;
        end
        tests_run++;
        if (lows !== 0 || vvs !== 0 || b1.vector !== 8'h00) begin
            tests_failed++;
            $display("FAIL rstmid_after: got lows=%0d vv=%0d vector=%h, expected 0 0 00", lows, vvs, b1.vector);
        end
    endtask

    initial begin
        reset = 1'b1;
        b1.INT = 1'b0; b1.IF_flag = 1'b0;
        b0.INT = 1'b0; b0.IF_flag = 1'b0;
        test_reset();
        test_mode1();
        test_gating();
        test_mode0();
        test_int_drop();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
